// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
// Shares the single data memory between the pipeline MEM stage (CPU port) and
// an auxiliary master (loader / debug port). One access is granted per cycle;
// the granted port is steered onto the memory bus, and read data comes back
// to its owner one cycle later. The MEM stage is stalled whenever it loses
// arbitration.
//
// Build option: define MEM_ARB_STARVE_GUARD_EN to add the starvation guard.
// After STARVE_LIMIT consecutive denied aux cycles, aux is forced one grant.
// Without the macro the CPU has strict priority and STARVE_LIMIT has no effect.

module data_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,

    input  logic        cpu_req_i,
    input  logic        cpu_we_i,
    input  logic        cpu_byte_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_wdata_i,
    output logic        cpu_stall_o,
    output logic [31:0] cpu_rdata_o,
    output logic        cpu_rvalid_o,

    input  logic        aux_req_i,
    input  logic        aux_we_i,
    input  logic        aux_byte_i,
    input  logic [31:0] aux_addr_i,
    input  logic [31:0] aux_wdata_i,
    output logic        aux_gnt_o,
    output logic [31:0] aux_rdata_o,
    output logic        aux_rvalid_o,

    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_o,
    output logic        mem_wren_o,
    output logic        mem_byte_mode_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic {
        S_CPU_PRI   = 1'b0,
        S_AUX_FORCE = 1'b1
    } state_t;

    state_t state;
    logic   cpu_gnt;
    logic   aux_gnt;
    logic   rsp_valid;
    logic   rsp_owner;   // 0 = CPU, 1 = aux

    // STARVE_LIMIT has to fit the 4-bit starvation counter (1..15).
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_starve_limit_out_of_range
    end

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_next;
    logic [3:0] starve_cnt;
    logic [3:0] starve_cnt_next;

    // FSM state and starvation counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_CPU_PRI;
            starve_cnt <= 4'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Counter update and next-state: count denied aux cycles, force aux once
    always_comb begin
        starve_cnt_next = starve_cnt;
        state_next      = state;

        if (!aux_req_i || aux_gnt) begin
            starve_cnt_next = 4'd0;
        end else if (cpu_gnt && (starve_cnt != 4'hF)) begin
            starve_cnt_next = starve_cnt + 4'd1;
        end

        case (state)
            S_CPU_PRI: begin
                // Switch as the count reaches the limit so the forced grant
                // lands on the very next cycle.
                if (starve_cnt_next >= LIMIT) begin
                    state_next = S_AUX_FORCE;
                end
            end
            S_AUX_FORCE: begin
                // Either aux took its forced grant or it stopped asking;
                // both cases return to CPU priority.
                state_next = S_CPU_PRI;
            end
            default: state_next = S_CPU_PRI;
        endcase
    end
`else
    // Strict CPU priority: the arbiter never leaves S_CPU_PRI.
    assign state = S_CPU_PRI;
`endif

    // Grant decision; nothing is granted while reset is held
    always_comb begin
        cpu_gnt = 1'b0;
        aux_gnt = 1'b0;
        if (!RST) begin
            if ((state == S_AUX_FORCE) && aux_req_i) begin
                aux_gnt = 1'b1;
            end else if (cpu_req_i) begin
                cpu_gnt = 1'b1;
            end else if (aux_req_i) begin
                aux_gnt = 1'b1;
            end
        end
    end

    // Steer the granted port onto the memory bus; idle bus is all zeros
    always_comb begin
        mem_address_o   = 32'd0;
        mem_data_o      = 32'd0;
        mem_wren_o      = 1'b0;
        mem_byte_mode_o = 1'b0;
        if (cpu_gnt) begin
            mem_address_o   = cpu_addr_i;
            mem_data_o      = cpu_wdata_i;
            mem_wren_o      = cpu_we_i;
            mem_byte_mode_o = cpu_byte_i;
        end else if (aux_gnt) begin
            mem_address_o   = aux_addr_i;
            mem_data_o      = aux_wdata_i;
            mem_wren_o      = aux_we_i;
            mem_byte_mode_o = aux_byte_i;
        end
    end

    assign cpu_stall_o = cpu_req_i & ~cpu_gnt & ~RST;
    assign aux_gnt_o   = aux_gnt;

    // Single-stage read tracking: memory latency is fixed at one cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rsp_valid <= 1'b0;
            rsp_owner <= 1'b0;
        end else begin
            rsp_valid <= (cpu_gnt & ~cpu_we_i) | (aux_gnt & ~aux_we_i);
            rsp_owner <= aux_gnt;
        end
    end

    assign cpu_rvalid_o = rsp_valid & ~rsp_owner;
    assign aux_rvalid_o = rsp_valid &  rsp_owner;
    assign cpu_rdata_o  = cpu_rvalid_o ? mem_data_i : 32'd0;
    assign aux_rdata_o  = aux_rvalid_o ? mem_data_i : 32'd0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed scenarios followed by randomized
// traffic, all checked against a behavioural reference model of the arbiter.

module tb_data_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cpu_req_i, cpu_we_i, cpu_byte_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i;
    logic        cpu_stall_o, cpu_rvalid_o;
    logic [31:0] cpu_rdata_o;
    logic        aux_req_i, aux_we_i, aux_byte_i;
    logic [31:0] aux_addr_i, aux_wdata_i;
    logic        aux_gnt_o, aux_rvalid_o;
    logic [31:0] aux_rdata_o;
    logic [31:0] mem_address_o, mem_data_o;
    logic        mem_wren_o, mem_byte_mode_o;
    logic [31:0] mem_data_i = 32'd0;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_byte_i(cpu_byte_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_stall_o(cpu_stall_o), .cpu_rdata_o(cpu_rdata_o), .cpu_rvalid_o(cpu_rvalid_o),
        .aux_req_i(aux_req_i), .aux_we_i(aux_we_i), .aux_byte_i(aux_byte_i),
        .aux_addr_i(aux_addr_i), .aux_wdata_i(aux_wdata_i),
        .aux_gnt_o(aux_gnt_o), .aux_rdata_o(aux_rdata_o), .aux_rvalid_o(aux_rvalid_o),
        .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
        .mem_wren_o(mem_wren_o), .mem_byte_mode_o(mem_byte_mode_o),
        .mem_data_i(mem_data_i)
    );

    // Memory environment: word array, read data one cycle after the address
    logic [31:0] env_mem [0:63];
    always @(posedge CLK) begin
        if (mem_wren_o) env_mem[mem_address_o[7:2]] <= mem_data_o;
        mem_data_i <= env_mem[mem_address_o[7:2]];
    end

    // Reference model state
    logic [31:0] ref_mem [0:63];
    logic        pend_v, pend_owner;
    logic [31:0] pend_data;
    int          streak;
    int          n_checks = 0;
    int          n_err = 0;
    logic        last_aux_gnt, last_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check all outputs at the falling edge, advance the model
    task automatic tick();
        logic        forced, eg_cpu, eg_aux, e_stall, e_we, e_byte;
        logic [31:0] e_addr, e_wdata;
        @(negedge CLK);
        last_aux_gnt = aux_gnt_o;
        last_stall   = cpu_stall_o;
        if (RST) begin
            chk("rst_stall", cpu_stall_o, 0);
            chk("rst_aux_gnt", aux_gnt_o, 0);
            chk("rst_cpu_rvalid", cpu_rvalid_o, 0);
            chk("rst_aux_rvalid", aux_rvalid_o, 0);
            chk("rst_cpu_rdata", cpu_rdata_o, 0);
            chk("rst_aux_rdata", aux_rdata_o, 0);
            chk("rst_mem_addr", mem_address_o, 0);
            chk("rst_mem_data", mem_data_o, 0);
            chk("rst_mem_wren", mem_wren_o, 0);
            chk("rst_mem_byte", mem_byte_mode_o, 0);
            pend_v = 1'b0;
            streak = 0;
        end else begin
            forced  = GUARD && aux_req_i && (streak >= LIMIT);
            eg_cpu  = cpu_req_i && !forced;
            eg_aux  = aux_req_i && (!cpu_req_i || forced);
            e_stall = cpu_req_i && !eg_cpu;
            e_addr  = eg_cpu ? cpu_addr_i  : eg_aux ? aux_addr_i  : 32'd0;
            e_wdata = eg_cpu ? cpu_wdata_i : eg_aux ? aux_wdata_i : 32'd0;
            e_we    = eg_cpu ? cpu_we_i    : eg_aux ? aux_we_i    : 1'b0;
            e_byte  = eg_cpu ? cpu_byte_i  : eg_aux ? aux_byte_i  : 1'b0;

            chk("cpu_stall", cpu_stall_o, e_stall);
            chk("aux_gnt", aux_gnt_o, eg_aux);
            chk("mem_addr", mem_address_o, e_addr);
            chk("mem_data", mem_data_o, e_wdata);
            chk("mem_wren", mem_wren_o, e_we);
            chk("mem_byte", mem_byte_mode_o, e_byte);
            chk("cpu_rvalid", cpu_rvalid_o, pend_v && !pend_owner);
            chk("aux_rvalid", aux_rvalid_o, pend_v && pend_owner);
            chk("cpu_rdata", cpu_rdata_o, (pend_v && !pend_owner) ? pend_data : 32'd0);
            chk("aux_rdata", aux_rdata_o, (pend_v && pend_owner) ? pend_data : 32'd0);

            pend_v = 1'b0;
            if (eg_cpu || eg_aux) begin
                if (e_we) begin
                    ref_mem[e_addr[7:2]] = e_wdata;
                end else begin
                    pend_v     = 1'b1;
                    pend_owner = eg_aux;
                    pend_data  = ref_mem[e_addr[7:2]];
                end
            end
            if (aux_req_i && eg_cpu) streak = (streak >= 15) ? 15 : streak + 1;
            else                     streak = 0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req_i = 0; cpu_we_i = 0; cpu_byte_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
        aux_req_i = 0; aux_we_i = 0; aux_byte_i = 0; aux_addr_i = 0; aux_wdata_i = 0;
    endtask

    initial begin
        int aux_cnt, stall_cnt;
        for (int i = 0; i < 64; i++) begin
            env_mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        pend_v = 1'b0; pend_owner = 1'b0; pend_data = 32'd0; streak = 0;
        last_aux_gnt = 1'b0; last_stall = 1'b0;
        idle_inputs();

        // Reset held with both ports requesting: every output stays 0
        RST = 1'b1;
        cpu_req_i = 1; aux_req_i = 1; cpu_addr_i = 32'h40; aux_addr_i = 32'h44;
        tick(); tick();
        RST = 1'b0;
        idle_inputs();
        tick(); tick();

        // CPU writes 0,4,8,12 (data = addr), then reads them back-to-back
        for (int a = 0; a < 16; a += 4) begin
            cpu_req_i = 1; cpu_we_i = 1; cpu_addr_i = a; cpu_wdata_i = a;
            tick();
        end
        for (int a = 0; a < 16; a += 4) begin
            cpu_req_i = 1; cpu_we_i = 0; cpu_addr_i = a; cpu_wdata_i = 0;
            tick();
        end
        idle_inputs();
        tick();

        // Aux write then read while the CPU is idle
        aux_req_i = 1; aux_we_i = 1; aux_addr_i = 16; aux_wdata_i = 32'h0011_0011;
        tick();
        aux_we_i = 0; aux_wdata_i = 0;
        tick();
        idle_inputs();
        tick();

        // Read-response routing: CPU reads addr 0, aux reads addr 4 next cycle
        cpu_req_i = 1; cpu_addr_i = 0;
        tick();
        idle_inputs();
        aux_req_i = 1; aux_addr_i = 4;
        tick();
        idle_inputs();
        tick();

        // Continuous contention for 20 cycles
        aux_cnt = 0; stall_cnt = 0;
        cpu_req_i = 1; cpu_addr_i = 8;
        aux_req_i = 1; aux_addr_i = 12;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (last_aux_gnt) aux_cnt++;
            if (last_stall)   stall_cnt++;
        end
        chk("contention_aux_grants", aux_cnt, GUARD ? 4 : 0);
        chk("contention_stalls", stall_cnt, GUARD ? 4 : 0);
        idle_inputs();
        tick();

        // Reset asserted in the cycle after a read grant kills the response
        cpu_req_i = 1; cpu_addr_i = 4;
        tick();
        RST = 1'b1;
        aux_req_i = 1; aux_addr_i = 8;
        tick();
        RST = 1'b0;
        idle_inputs();
        tick();

        // Randomized traffic; a stalled CPU request is held stable
        for (int c = 0; c < 400; c++) begin
            if (!last_stall) begin
                cpu_req_i   = ($urandom_range(0, 9) < 7);
                cpu_we_i    = $urandom_range(0, 1);
                cpu_byte_i  = $urandom_range(0, 1);
                cpu_addr_i  = $urandom & 32'h0000_00FF;
                cpu_wdata_i = $urandom;
            end
            aux_req_i   = $urandom_range(0, 1);
            aux_we_i    = $urandom_range(0, 1);
            aux_byte_i  = $urandom_range(0, 1);
            aux_addr_i  = $urandom & 32'h0000_00FF;
            aux_wdata_i = $urandom;
            tick();
        end
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single data memory (DataMemoryManager) between the pipeline MEM stage and an auxiliary master, such as a program/image loader or debug port. It sits between the EX/MEM pipe outputs and the memory. It grants one access per cycle, steers address, write data, write-enable and byte mode to the memory, and routes read data back to the owner one cycle later. It stalls the pipeline whenever the MEM stage loses arbitration.

## Interface
- STARVE_LIMIT, 4, consecutive cycles the aux port may be denied while requesting before it is forced a grant (used only with the starvation guard); range 1–15
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- cpu_req_i  in  1  MEM stage requests access this cycle
- cpu_we_i  in  1  1 = write, 0 = read
- cpu_byte_i  in  1  byte mode for this access
- cpu_addr_i  in  32  byte address (AluResult of MEM stage)
- cpu_wdata_i  in  32  write data (RD2 of MEM stage)
- cpu_stall_o  out  1  MEM stage must hold; combinational
- cpu_rdata_o  out  32  read data, valid when cpu_rvalid_o
- cpu_rvalid_o  out  1  CPU read data returned this cycle
- aux_req_i, aux_we_i, aux_byte_i  in  1  aux request, write, byte mode
- aux_addr_i, aux_wdata_i  in  32  aux address, write data
- aux_gnt_o  out  1  aux access accepted this cycle; combinational
- aux_rdata_o  out  32  aux read data
- aux_rvalid_o  out  1  aux read data returned this cycle
- mem_address_o  out  32  to memory address_i
- mem_data_o  out  32  to memory data_i
- mem_wren_o  out  1  to memory wren_i
- mem_byte_mode_o  out  1  to memory byte_mode_i
- mem_data_i  in  32  from memory data_o; valid one cycle after the read address is presented

## Operation
- **FSM states:** S_CPU_PRI (reset state) and S_AUX_FORCE.
- **Grant in S_CPU_PRI:**
  - cpu_req_i high: CPU granted.
  - cpu_req_i low and aux_req_i high: aux granted.
- **Grant in S_AUX_FORCE:**
  - aux_req_i high: aux granted.
  - aux_req_i low: CPU granted if it requests.
- **Memory-side outputs:**
  - Granted port's addr/wdata/byte are muxed onto mem_*.
  - mem_wren_o = granted port's we.
  - With no grant: all mem_* outputs are 0.
- **Stall and accept:**
  - cpu_stall_o = cpu_req_i & ~cpu_granted.
  - aux_gnt_o = aux granted.
- **Writes:** complete in the grant cycle; no rvalid is generated.
- **Read tracking:** a read grant sets registered rsp_valid plus rsp_owner (0 = CPU, 1 = aux) for the next cycle.
- **Read return:**
  - Owner's rvalid is high for exactly one cycle.
  - Owner's rdata = mem_data_i in that cycle.
  - Non-owner rdata = 0.
- **Back-to-back reads:** supported, one per cycle. Response tracking is a single stage because latency is fixed at 1.
- **Starvation counter** (4-bit, saturating):
  - Increments when aux_req_i is high and CPU is granted.
  - Clears on any aux grant or when aux_req_i is low.
- **Transitions:**
  - S_CPU_PRI→S_AUX_FORCE when the counter reaches STARVE_LIMIT.
  - S_AUX_FORCE→S_CPU_PRI after one aux grant, or when aux_req_i is low in S_AUX_FORCE.

## Timing
- **Reset (asynchronous):** while RST is high and after release, until the first request:
  - All outputs are 0.
  - State = S_CPU_PRI; counter = 0; rsp_valid = 0.
- **Reset mid-read:** asserting RST in the cycle after a read grant kills the pending rvalid.
- **Latency:**
  - Grant, stall and mem_* outputs are combinational in the request cycle (0 cycles).
  - Read data returns at cycle N+1 for a grant at cycle N.
- **Simultaneous requests:** CPU wins unless the FSM is in S_AUX_FORCE.
- **Stall behaviour:** a stalled CPU request must be held stable by the pipeline. The request is served in the first cycle it is granted; cpu_stall_o drops in that same cycle.
- **Address handling:** no alignment checks; the address passes through unchanged. Byte/word handling belongs to the memory manager.

## Configuration
- **MEM_ARB_STARVE_GUARD_EN defined:** starvation counter and S_AUX_FORCE are implemented as described.
- **MEM_ARB_STARVE_GUARD_EN undefined:**
  - Strict CPU priority; FSM stays in S_CPU_PRI.
  - Counter is not instantiated and STARVE_LIMIT is ignored.
  - Aux can be starved indefinitely by continuous CPU requests.

## Test plan
- **Reset:** assert RST mid-run -> all outputs 0 immediately. After release, with no requests, mem_wren_o = 0 and both rvalid = 0.
- **CPU write then read:** CPU writes addr 0, 4, 8, 12 with data = addr, one per cycle. Then it reads the same four addresses back-to-back -> cpu_rvalid_o high on each following cycle; cpu_rdata_o = 0, 4, 8, 12; cpu_stall_o never asserts.
- **Aux while idle:** aux writes 0x110011 to addr 16, then reads it -> aux_gnt_o = 1 both cycles; aux_rvalid_o one cycle after the read; aux_rdata_o = 0x110011; cpu_rvalid_o stays 0.
- **Contention, guard enabled (STARVE_LIMIT = 4):** cpu_req_i and aux_req_i are held high continuously -> CPU is granted 4 cycles, then aux is granted 1 cycle with cpu_stall_o = 1, repeating in a 5-cycle period.
- **Contention, guard disabled:** same stimulus with the macro undefined -> aux_gnt_o stays 0 for 20 cycles; cpu_stall_o stays 0.
- **Read-response routing:** CPU reads addr 0 at cycle N, aux reads addr 4 at cycle N+1 -> cpu_rvalid_o only at N+1, aux_rvalid_o only at N+2; each rdata matches its own address contents.
